round_judge: RTL
================

// Module: round_judge
// PURPOSE
//  Producer side of the per-round result interface consumed by the scoring block (en/combo/life).
//  Holds the current pattern and checks the player's button presses against it, one symbol at a time.
//  Enforces a per-press timeout and issues exactly one result strobe per round: hit (combo) or miss (life loss).
//  Sits between the pattern generator/display FSM and the scoring block.
// PARAMETERS
//  MAX_LEN    16   max pattern length (symbols); pattern RAM depth
//  SYM_W      2    symbol width (4 buttons)
//  TIMEOUT_T  3000 tick pulses allowed between presses (3 s at 1 ms tick)
// PORTS
//  clk          in   1                  clock
//  reset        in   1                  synchronous, active-high
//  pat_we       in   1                  pattern write strobe (accepted in IDLE only)
//  pat_addr     in   $clog2(MAX_LEN)    pattern write address
//  pat_sym      in   SYM_W              pattern symbol to write
//  start        in   1                  begin round (pulse); accepted in IDLE only
//  pat_len      in   $clog2(MAX_LEN)+1  symbols in this round, sampled on accepted start
//  btn_valid    in   1                  one-cycle debounced button press
//  btn_sym      in   SYM_W              pressed button id
//  tick         in   1                  timebase pulse for timeout
//  game_over    in   1                  high when scoring block reports lives==0
//  busy         out  1                  high in COLLECT and RESULT
//  idx          out  $clog2(MAX_LEN)    index of next expected symbol
//  res_en       out  1                  one-cycle result strobe (drives scorer en)
//  res_combo    out  1                  1 = round hit (drives scorer combo)
//  res_life     out  1                  0 = round miss, lose a life (drives scorer life)
// BEHAVIOUR
//  Reset: state IDLE, idx=0, timer=0, busy=0, res_en=0, res_combo=0, res_life=1. RAM contents not cleared.
//  res_combo/res_life are registered and hold their last value between strobes; only meaningful with res_en.
//  States: IDLE -> COLLECT -> RESULT -> IDLE.
//  IDLE: pat_we writes RAM[pat_addr]<=pat_sym. start && !game_over && pat_len!=0 -> COLLECT,
//   len<=min(pat_len,MAX_LEN), idx<=0, timer<=0. start with pat_len==0 or game_over is ignored.
//  COLLECT: pat_we and start ignored. Combinational read of RAM[idx].
//   btn_valid && btn_sym==RAM[idx]: if idx==len-1 -> RESULT with hit, else idx<=idx+1, timer<=0.
//   btn_valid && mismatch -> RESULT with miss.
//   no btn_valid, tick: timer<=timer+1; timer==TIMEOUT_T-1 on tick -> RESULT with miss.
//   btn_valid and the timeout-expiring tick in the same cycle: the press wins, timeout discarded.
//  RESULT (1 cycle): res_en=1; hit: res_combo=1,res_life=1; miss: res_combo=0,res_life=0. Next: IDLE, idx<=0.
//  Latency: final/mismatching press at cycle N -> res_en high at cycle N+1, busy low at N+2.
//  Exactly one res_en per accepted start; none otherwise. btn_valid in IDLE/RESULT ignored.
//  game_over asserting mid-COLLECT does not abort; the round completes normally.
//  reset mid-round: back to IDLE the next cycle, no res_en emitted.
//  timer width: $clog2(TIMEOUT_T+1); never wraps (cleared on every accepted press).
// STRUCTURE
//  memory_game_pkg: typedef enum logic[1:0] {J_IDLE,J_COLLECT,J_RESULT} judge_state_t;
//   localparams SYM_W, MAX_LEN, TIMEOUT_T shared with generator and display FSM.
//  Sub-module pattern_ram: MAX_LEN x SYM_W, synchronous write, asynchronous read.
//  Top: state register, idx/len/timer counters, registered result outputs.
// TESTING
//  1 load {1,3,0,2}, start pat_len=4, press 1,3,0,2 -> single res_en, combo=1 life=1, busy low 2 cycles after last press.
//  2 same pattern, press 1,2 -> res_en the cycle after the press of 2, combo=0 life=0; later presses ignored.
//  3 TIMEOUT_T=5, start, no presses, 5 ticks -> res_en with life=0 on cycle after 5th tick.
//  4 on the 5th tick also btn_valid with correct sym -> no miss, idx advances, timer resets to 0.
//  5 start with pat_len=0 or game_over=1 -> stays IDLE, busy=0, no res_en; pat_len=20 clamps to 16.
//  6 reset asserted after 2 correct presses -> IDLE, idx=0, no res_en; pat_we during COLLECT leaves RAM unchanged.

Source files
------------

// File: rtl/round_judge_pkg.sv
// round_judge_pkg: shared state encoding and game-wide sizing constants
package round_judge_pkg;
    typedef enum logic [1:0] {J_IDLE, J_COLLECT, J_RESULT} judge_state_t;
    localparam int SYM_W     = 2;
    localparam int MAX_LEN   = 16;
    localparam int TIMEOUT_T = 3000;
endpackage

// File: rtl/round_judge_if.sv
// round_judge_if: pattern load, round control, button input and per-round result strobe
interface round_judge_if #(
    parameter int MAX_LEN = round_judge_pkg::MAX_LEN,
    parameter int SYM_W   = round_judge_pkg::SYM_W
);
    localparam int AW = $clog2(MAX_LEN);
    localparam int LW = AW + 1;
    logic             pat_we;
    logic [AW-1:0]    pat_addr;
    logic [SYM_W-1:0] pat_sym;
    logic             start;
    logic [LW-1:0]    pat_len;
    logic             btn_valid;
    logic [SYM_W-1:0] btn_sym;
    logic             tick;
    logic             game_over;
    logic             busy;
    logic [AW-1:0]    idx;
    logic             res_en;
    logic             res_combo;
    logic             res_life;
    modport master (
        output pat_we, pat_addr, pat_sym, start, pat_len, btn_valid, btn_sym, tick, game_over,
        input  busy, idx, res_en, res_combo, res_life
    );
    modport slave (
        input  pat_we, pat_addr, pat_sym, start, pat_len, btn_valid, btn_sym, tick, game_over,
        output busy, idx, res_en, res_combo, res_life
    );
endinterface

// File: rtl/round_judge_pattern_ram.sv
// round_judge_pattern_ram: pattern storage, synchronous write and asynchronous read
module round_judge_pattern_ram #(
    parameter int MAX_LEN = 16,
    parameter int SYM_W   = 2
) (
    input  logic                       clk,
    input  logic                       i_we,
    input  logic [$clog2(MAX_LEN)-1:0] i_waddr,
    input  logic [SYM_W-1:0]           i_wdata,
    input  logic [$clog2(MAX_LEN)-1:0] i_raddr,
    output logic [SYM_W-1:0]           o_rdata
);
    logic [SYM_W-1:0] r_mem [MAX_LEN];

    // contents are intentionally not reset; the generator reloads before each round
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/round_judge.sv
// round_judge: checks button presses against the stored pattern and issues one hit/miss strobe per round
module round_judge #(
    parameter int MAX_LEN   = round_judge_pkg::MAX_LEN,
    parameter int SYM_W     = round_judge_pkg::SYM_W,
    parameter int TIMEOUT_T = round_judge_pkg::TIMEOUT_T
) (
    input  logic         clk,
    input  logic         reset,
    round_judge_if.slave bus
);
    import round_judge_pkg::*;

    localparam int AW = $clog2(MAX_LEN);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_T + 1);

    judge_state_t     r_state;
    logic [AW-1:0]    r_idx;
    logic [LW-1:0]    r_len;
    logic [TW-1:0]    r_timer;
    logic             r_busy;
    logic             r_en;
    logic             r_combo;
    logic             r_life;
    logic             w_we;
    logic [SYM_W-1:0] w_sym;
    logic [LW-1:0]    w_len;
    logic             w_match;
    logic             w_last;
    logic             w_tmo;
    logic             w_hit;
    logic             w_done;

    // the pattern is frozen once a round is collecting
    assign w_we    = bus.pat_we && r_state == J_IDLE;
    assign w_len   = bus.pat_len > LW'(MAX_LEN) ? LW'(MAX_LEN) : bus.pat_len;
    assign w_match = bus.btn_sym == w_sym;
    assign w_last  = LW'(r_idx) == r_len - LW'(1);
    assign w_tmo   = r_timer == TW'(TIMEOUT_T - 1);
    // a press in the same cycle as the expiring tick takes priority over the timeout
    assign w_hit   = bus.btn_valid && w_match;
    assign w_done  = bus.btn_valid ? (!w_match || w_last) : (bus.tick && w_tmo);

    round_judge_pattern_ram #(.MAX_LEN(MAX_LEN), .SYM_W(SYM_W)) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (bus.pat_addr),
        .i_wdata (bus.pat_sym),
        .i_raddr (r_idx),
        .o_rdata (w_sym)
    );

    // round FSM with counters and registered result outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= J_IDLE;
            r_idx   <= '0;
            r_len   <= '0;
            r_timer <= '0;
            r_busy  <= 1'b0;
            r_en    <= 1'b0;
            r_combo <= 1'b0;
            r_life  <= 1'b1;
        end else begin
            r_en <= 1'b0;
            case (r_state)
                J_IDLE: begin
                    if (bus.start && !bus.game_over && bus.pat_len != '0) begin
                        r_state <= J_COLLECT;
                        r_busy  <= 1'b1;
                        r_len   <= w_len;
                        r_idx   <= '0;
                        r_timer <= '0;
                    end
                end
                J_COLLECT: begin
                    if (w_done) begin
                        r_state <= J_RESULT;
                        r_en    <= 1'b1;
                        r_combo <= w_hit;
                        r_life  <= w_hit;
                    end else if (bus.btn_valid) begin
                        r_idx   <= r_idx + AW'(1);
                        r_timer <= '0;
                    end else if (bus.tick) begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                J_RESULT: begin
                    r_state <= J_IDLE;
                    r_busy  <= 1'b0;
                    r_idx   <= '0;
                end
                default: r_state <= J_IDLE;
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.idx       = r_idx;
    assign bus.res_en    = r_en;
    assign bus.res_combo = r_combo;
    assign bus.res_life  = r_life;
endmodule
